// File: rtl/mem_stage_if.sv
// Bus bundle between the execute stage, the data SRAM read port and the memory stage.
// The memory stage takes the slave view; the upstream/downstream environment takes the master view.
interface mem_stage_if;
  localparam int StallBus     = 6;
  localparam int ExToMemWd    = 79;
  localparam int MemToWbWd    = 70;
  localparam int MemToRfBusWd = 38;

  logic [StallBus-1:0]     stall;
  logic [ExToMemWd-1:0]    ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MemToWbWd-1:0]    mem_to_wb_bus;
  logic [MemToRfBusWd-1:0] mem_to_rf_bus;

  modport master (
    output stall,
    output ex_to_mem_bus,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_rf_bus
  );

  modport slave (
    input  stall,
    input  ex_to_mem_bus,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_rf_bus
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX->MEM bus, extends load data from the
// data SRAM, and drives writeback and forwarding buses; a one-entry buffer keeps load data across stalls.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);
  localparam int ExToMemWd = 79;

  localparam logic [2:0] LdLw  = 3'b000;
  localparam logic [2:0] LdLb  = 3'b001;
  localparam logic [2:0] LdLbu = 3'b010;
  localparam logic [2:0] LdLh  = 3'b011;
  localparam logic [2:0] LdLhu = 3'b100;

  logic [ExToMemWd-1:0] ex_mem_q, ex_mem_d;
  logic [31:0]          hold_data_q, hold_data_d;
  logic                 hold_valid_q, hold_valid_d;

  logic        stall_ex;
  logic        stall_mem;
  logic        reg_update;

  logic [2:0]  ld_op;
  logic [31:0] mem_pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [1:0]  off;
  logic        is_load;

  logic [31:0] raw_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  assign stall_ex  = bus.stall[3];
  assign stall_mem = bus.stall[4];

  // Register changes unless both EX and MEM are held; a change always retires the hold buffer.
  assign reg_update = !(stall_ex && stall_mem);

  assign ld_op        = ex_mem_q[78:76];
  assign mem_pc       = ex_mem_q[75:44];
  assign data_ram_en  = ex_mem_q[43];
  assign data_ram_wen = ex_mem_q[42:39];
  assign sel_rf_res   = ex_mem_q[38];
  assign rf_we        = ex_mem_q[37];
  assign rf_waddr     = ex_mem_q[36:32];
  assign ex_result    = ex_mem_q[31:0];
  assign off          = ex_result[1:0];

  assign is_load = data_ram_en && (data_ram_wen == 4'b0000) && sel_rf_res;

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (stall_ex && !stall_mem) begin
      ex_mem_d = '0;
    end else if (!stall_ex) begin
      ex_mem_d = bus.ex_to_mem_bus;
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (reg_update) begin
      hold_valid_d = 1'b0;
      hold_data_d  = '0;
    end else if (is_load && stall_mem && !hold_valid_q) begin
      // SRAM data is only valid in the load's first cycle here, so keep it before it goes stale.
      hold_valid_d = 1'b1;
      hold_data_d  = bus.data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_q     <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      ex_mem_q     <= ex_mem_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign raw_data = hold_valid_q ? hold_data_q : bus.data_sram_rdata;

  always_comb begin
    byte_sel = raw_data[7:0];
    case (off)
      2'b00:   byte_sel = raw_data[7:0];
      2'b01:   byte_sel = raw_data[15:8];
      2'b10:   byte_sel = raw_data[23:16];
      default: byte_sel = raw_data[31:24];
    endcase
  end

  // Halfword loads are assumed aligned upstream, so only off[1] matters.
  assign half_sel = off[1] ? raw_data[31:16] : raw_data[15:0];

  always_comb begin
    load_data = raw_data;
    case (ld_op)
      LdLw:    load_data = raw_data;
      LdLb:    load_data = {{24{byte_sel[7]}}, byte_sel};
      LdLbu:   load_data = {24'h000000, byte_sel};
      LdLh:    load_data = {{16{half_sel[15]}}, half_sel};
      LdLhu:   load_data = {16'h0000, half_sel};
      default: load_data = raw_data;
    endcase
  end

  assign rf_wdata = sel_rf_res ? load_data : ex_result;

  assign bus.mem_to_wb_bus = {mem_pc, rf_we, rf_waddr, rf_wdata};
  assign bus.mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, load extension sweep,
// stalled-load hold buffer, bubble insertion and reset during a stalled load.
module tb_mem_stage;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_stage_if bus ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [78:0] make_ex(input logic [2:0] ld_op, input logic [31:0] pc,
                                          input logic en, input logic [3:0] wen, input logic sel,
                                          input logic we, input logic [4:0] waddr,
                                          input logic [31:0] result);
    return {ld_op, pc, en, wen, sel, we, waddr, result};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] exp;
    string       tag;
  } load_vec_t;

  load_vec_t sweep [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sweep[0] = '{3'b001, 2'd3, 32'hFFFFFF80, "lb_off3"};
    sweep[1] = '{3'b010, 2'd1, 32'h000000F2, "lbu_off1"};
    sweep[2] = '{3'b011, 2'd2, 32'hFFFF8081, "lh_off2"};
    sweep[3] = '{3'b100, 2'd0, 32'h0000F2F3, "lhu_off0"};
    sweep[4] = '{3'b000, 2'd0, 32'h8081F2F3, "lw"};

    rst                 = 1'b1;
    bus.stall           = '0;
    bus.ex_to_mem_bus   = '0;
    bus.data_sram_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_val("reset_wb", bus.mem_to_wb_bus, 70'd0);
    check_val("reset_rf", {32'd0, bus.mem_to_rf_bus}, 70'd0);
    check_val("reset_hold", {69'd0, dut.hold_valid_q}, 70'd0);

    // ALU pass-through
    bus.ex_to_mem_bus = make_ex(3'b000, 32'hBFC00010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h12345678);
    tick();
    check_val("alu_wb", bus.mem_to_wb_bus, {32'hBFC00010, 1'b1, 5'd5, 32'h12345678});
    check_val("alu_rf", {32'd0, bus.mem_to_rf_bus}, {32'd0, 1'b1, 5'd5, 32'h12345678});

    // Load extension sweep
    for (int i = 0; i < 5; i++) begin
      bus.ex_to_mem_bus = make_ex(sweep[i].op, 32'hBFC00100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9,
                                  {30'h04000000, sweep[i].off});
      bus.data_sram_rdata = 32'h0;
      tick();
      bus.data_sram_rdata = 32'h8081F2F3;
      #1;
      check_val(sweep[i].tag, {38'd0, bus.mem_to_wb_bus[31:0]}, {38'd0, sweep[i].exp});
    end
    check_val("sweep_no_hold", {69'd0, dut.hold_valid_q}, 70'd0);

    // Stalled LW
    bus.ex_to_mem_bus = make_ex(3'b000, 32'hBFC00200, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h10000000);
    tick();
    bus.data_sram_rdata = 32'hCAFEBABE;
    #1;
    check_val("stall_first", {38'd0, bus.mem_to_rf_bus[31:0]}, {38'd0, 32'hCAFEBABE});
    bus.stall         = 6'b011111;
    bus.ex_to_mem_bus = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.data_sram_rdata = (c % 2 == 0) ? 32'hDEADBEEF : 32'h01234567;
      #1;
      check_val("stall_hold_data", {38'd0, bus.mem_to_rf_bus[31:0]}, {38'd0, 32'hCAFEBABE});
      check_val("stall_hold_valid", {69'd0, dut.hold_valid_q}, 70'd1);
    end
    bus.stall = '0;
    #1;
    check_val("release_wb", bus.mem_to_wb_bus, {32'hBFC00200, 1'b1, 5'd7, 32'hCAFEBABE});
    tick();
    check_val("release_hold_clear", {69'd0, dut.hold_valid_q}, 70'd0);
    check_val("release_next_zero", bus.mem_to_wb_bus, 70'd0);

    // Bubble insertion
    bus.ex_to_mem_bus = make_ex(3'b000, 32'hBFC00300, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0000AAAA);
    tick();
    check_val("pre_bubble_we", {69'd0, bus.mem_to_wb_bus[37]}, 70'd1);
    bus.stall = 6'b001000;
    tick();
    check_val("bubble_wb", bus.mem_to_wb_bus, 70'd0);
    check_val("bubble_rf", {32'd0, bus.mem_to_rf_bus}, 70'd0);

    // Reset during a stalled LB
    bus.stall         = '0;
    bus.ex_to_mem_bus = make_ex(3'b001, 32'hBFC00400, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h20000000);
    tick();
    bus.data_sram_rdata = 32'h8081F2F3;
    bus.stall           = 6'b011111;
    bus.ex_to_mem_bus   = '0;
    #1;
    check_val("rst_lb_first", {38'd0, bus.mem_to_rf_bus[31:0]}, {38'd0, 32'hFFFFFFF3});
    tick();
    bus.data_sram_rdata = 32'h11111111;
    #1;
    check_val("rst_lb_held", {38'd0, bus.mem_to_rf_bus[31:0]}, {38'd0, 32'hFFFFFFF3});
    check_val("rst_lb_hold_valid", {69'd0, dut.hold_valid_q}, 70'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrst_wb", bus.mem_to_wb_bus, 70'd0);
    check_val("midrst_rf", {32'd0, bus.mem_to_rf_bus}, 70'd0);
    check_val("midrst_hold", {69'd0, dut.hold_valid_q}, 70'd0);
    bus.stall         = '0;
    bus.ex_to_mem_bus = make_ex(3'b000, 32'hBFC00500, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h30000000);
    tick();
    bus.data_sram_rdata = 32'h5A5A1234;
    #1;
    check_val("post_rst_lw", bus.mem_to_wb_bus, {32'hBFC00500, 1'b1, 5'd6, 32'h5A5A1234});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
